// File: rtl/reg_bank_8x32_wr_pkg.sv
// Shared constants and helpers for the 8x32 write-decoded register bank.
// Imported by the interface, the decoder and the top.
package reg_bank_8x32_wr_pkg;

    localparam int unsigned NUM_ENTRIES = 8;
    localparam int unsigned SEL_W       = 3;

    // Entry 0 counts as written from reset when it is hard-wired to zero.
    function automatic logic [NUM_ENTRIES-1:0] valid_mask_rst(input bit zero_reg);
        return {{(NUM_ENTRIES - 1){1'b0}}, zero_reg};
    endfunction

endpackage

// File: rtl/reg_bank_8x32_wr_if.sv
// Write/read bus of the register bank.
// master drives requests and selects; slave returns read data, valids and acks.
interface reg_bank_8x32_wr_if
    import reg_bank_8x32_wr_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) ();

    logic                   wr_en;
    logic [SEL_W-1:0]       wr_sel;
    logic [WIDTH-1:0]       wr_data;
    logic [SEL_W-1:0]       rd_sel_a;
    logic [SEL_W-1:0]       rd_sel_b;
    logic [WIDTH-1:0]       rd_data_a;
    logic [WIDTH-1:0]       rd_data_b;
    logic                   rd_vld_a;
    logic                   rd_vld_b;
    logic                   wr_ack;
    logic [NUM_ENTRIES-1:0] valid_mask;

    modport master (
        output wr_en,
        output wr_sel,
        output wr_data,
        output rd_sel_a,
        output rd_sel_b,
        input  rd_data_a,
        input  rd_data_b,
        input  rd_vld_a,
        input  rd_vld_b,
        input  wr_ack,
        input  valid_mask
    );

    modport slave (
        input  wr_en,
        input  wr_sel,
        input  wr_data,
        input  rd_sel_a,
        input  rd_sel_b,
        output rd_data_a,
        output rd_data_b,
        output rd_vld_a,
        output rd_vld_b,
        output wr_ack,
        output valid_mask
    );

endinterface

// File: rtl/reg_bank_8x32_wr_decoder_3x8.sv
// 3-to-8 write-enable decoder: one-hot when enabled, all zero otherwise.
module decoder_3x8
    import reg_bank_8x32_wr_pkg::*;
(
    input  logic [SEL_W-1:0]       sel_i,
    input  logic                   en_i,
    output logic [NUM_ENTRIES-1:0] dec_o
);

    always_comb begin
        dec_o = '0;
        if (en_i) begin
            dec_o[sel_i] = 1'b1;
        end
    end

endmodule

// File: rtl/reg_bank_8x32_wr.sv
// 8-entry register bank with decoded writes, two combinational read ports,
// optional same-cycle write bypass, per-entry valid bits and a registered write ack.
module reg_bank_8x32_wr
    import reg_bank_8x32_wr_pkg::*;
#(
    parameter int unsigned WIDTH    = 32,
    parameter bit          ZERO_REG = 1'b1,
    parameter bit          BYPASS   = 1'b1
) (
    input  logic              clk,
    input  logic              reset,
    reg_bank_8x32_wr_if.slave bus
);

    logic [WIDTH-1:0]       mem_q [NUM_ENTRIES];
    logic [WIDTH-1:0]       mem_d [NUM_ENTRIES];
    logic [NUM_ENTRIES-1:0] valid_mask_q;
    logic [NUM_ENTRIES-1:0] valid_mask_d;
    logic                   wr_ack_q;
    logic                   wr_ack_d;

    logic                   dec_en;
    logic [NUM_ENTRIES-1:0] we;

    // Writes to the hard-wired zero entry never reach the decoder, so they are
    // neither stored nor acknowledged.
    assign dec_en = bus.wr_en && !(ZERO_REG && (bus.wr_sel == '0));

    decoder_3x8 u_decoder (
        .sel_i (bus.wr_sel),
        .en_i  (dec_en),
        .dec_o (we)
    );

    always_comb begin
        for (int i = 0; i < NUM_ENTRIES; i++) begin
            mem_d[i] = we[i] ? bus.wr_data : mem_q[i];
        end
        valid_mask_d = valid_mask_q | we;
        wr_ack_d     = |we;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                mem_q[i] <= '0;
            end
            valid_mask_q <= valid_mask_rst(ZERO_REG);
            wr_ack_q     <= 1'b0;
        end else begin
            for (int i = 0; i < NUM_ENTRIES; i++) begin
                mem_q[i] <= mem_d[i];
            end
            valid_mask_q <= valid_mask_d;
            wr_ack_q     <= wr_ack_d;
        end
    end

    // we[sel] already excludes the zero entry and idle cycles, so it is the bypass hit.
    always_comb begin
        bus.rd_data_a = mem_q[bus.rd_sel_a];
        bus.rd_vld_a  = valid_mask_q[bus.rd_sel_a];
        if (BYPASS && we[bus.rd_sel_a]) begin
            bus.rd_data_a = bus.wr_data;
            bus.rd_vld_a  = 1'b1;
        end
    end

    always_comb begin
        bus.rd_data_b = mem_q[bus.rd_sel_b];
        bus.rd_vld_b  = valid_mask_q[bus.rd_sel_b];
        if (BYPASS && we[bus.rd_sel_b]) begin
            bus.rd_data_b = bus.wr_data;
            bus.rd_vld_b  = 1'b1;
        end
    end

    assign bus.wr_ack     = wr_ack_q;
    assign bus.valid_mask = valid_mask_q;

endmodule

// File: tb/tb_reg_bank_8x32_wr.sv
// Directed, table-driven bench for reg_bank_8x32_wr; a second instance with
// BYPASS=0 shares the same stimulus.
module tb_reg_bank_8x32_wr;
    import reg_bank_8x32_wr_pkg::*;

    logic clk;
    logic reset;
    int   tests;
    int   failures;

    reg_bank_8x32_wr_if #(.WIDTH(32)) bus ();
    reg_bank_8x32_wr_if #(.WIDTH(32)) bus_nb ();

    reg_bank_8x32_wr #(.WIDTH(32), .ZERO_REG(1'b1), .BYPASS(1'b1)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    reg_bank_8x32_wr #(.WIDTH(32), .ZERO_REG(1'b1), .BYPASS(1'b0)) u_dut_nb (
        .clk   (clk),
        .reset (reset),
        .bus   (bus_nb.slave)
    );

    assign bus_nb.wr_en    = bus.wr_en;
    assign bus_nb.wr_sel   = bus.wr_sel;
    assign bus_nb.wr_data  = bus.wr_data;
    assign bus_nb.rd_sel_a = bus.rd_sel_a;
    assign bus_nb.rd_sel_b = bus.rd_sel_b;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        wr_en;
        logic [2:0]  wr_sel;
        logic [31:0] wr_data;
        logic [2:0]  rd_sel_a;
        logic [2:0]  rd_sel_b;
        logic [31:0] exp_a;
        logic [31:0] exp_b;
        logic        exp_vld_a;
        logic        exp_vld_b;
        logic        exp_ack;
        logic [7:0]  exp_mask;
        logic [31:0] nb_a;
        logic [31:0] nb_b;
        logic        nb_vld_a;
        logic        nb_vld_b;
    } vec_t;

    vec_t vec [9];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic en, input logic [2:0] sel, input logic [31:0] data);
        bus.wr_en   = en;
        bus.wr_sel  = sel;
        bus.wr_data = data;
    endtask

    initial begin
        tests    = 0;
        failures = 0;

        // wr_en, wr_sel, wr_data, rd_a, rd_b, exp_a, exp_b, vld_a, vld_b, ack, mask,
        // nb_a, nb_b, nb_vld_a, nb_vld_b
        vec[0] = '{1'b1, 3'd5, 32'hDEADBEEF, 3'd5, 3'd0, 32'hDEADBEEF, 32'h0, 1'b1, 1'b1,
                   1'b0, 8'h01, 32'h0, 32'h0, 1'b0, 1'b1};
        vec[1] = '{1'b0, 3'd0, 32'h0, 3'd5, 3'd4, 32'hDEADBEEF, 32'h0, 1'b1, 1'b0,
                   1'b1, 8'h21, 32'hDEADBEEF, 32'h0, 1'b1, 1'b0};
        vec[2] = '{1'b0, 3'd0, 32'h0, 3'd5, 3'd5, 32'hDEADBEEF, 32'hDEADBEEF, 1'b1, 1'b1,
                   1'b0, 8'h21, 32'hDEADBEEF, 32'hDEADBEEF, 1'b1, 1'b1};
        vec[3] = '{1'b1, 3'd0, 32'h12345678, 3'd0, 3'd0, 32'h0, 32'h0, 1'b1, 1'b1,
                   1'b0, 8'h21, 32'h0, 32'h0, 1'b1, 1'b1};
        vec[4] = '{1'b0, 3'd0, 32'h0, 3'd0, 3'd0, 32'h0, 32'h0, 1'b1, 1'b1,
                   1'b0, 8'h21, 32'h0, 32'h0, 1'b1, 1'b1};
        vec[5] = '{1'b1, 3'd3, 32'hA5A5A5A5, 3'd3, 3'd3, 32'hA5A5A5A5, 32'hA5A5A5A5, 1'b1, 1'b1,
                   1'b0, 8'h21, 32'h0, 32'h0, 1'b0, 1'b0};
        vec[6] = '{1'b0, 3'd0, 32'h0, 3'd3, 3'd5, 32'hA5A5A5A5, 32'hDEADBEEF, 1'b1, 1'b1,
                   1'b1, 8'h29, 32'hA5A5A5A5, 32'hDEADBEEF, 1'b1, 1'b1};
        vec[7] = '{1'b1, 3'd5, 32'hCAFEF00D, 3'd5, 3'd2, 32'hCAFEF00D, 32'h0, 1'b1, 1'b0,
                   1'b0, 8'h29, 32'hDEADBEEF, 32'h0, 1'b1, 1'b0};
        vec[8] = '{1'b0, 3'd0, 32'h0, 3'd5, 3'd3, 32'hCAFEF00D, 32'hA5A5A5A5, 1'b1, 1'b1,
                   1'b1, 8'h29, 32'hCAFEF00D, 32'hA5A5A5A5, 1'b1, 1'b1};

        // Reset held for two edges
        reset        = 1'b1;
        drive(1'b0, 3'd0, 32'h0);
        bus.rd_sel_a = 3'd0;
        bus.rd_sel_b = 3'd0;
        step();
        step();
        reset = 1'b0;
        check("reset valid_mask", {24'h0, bus.valid_mask}, 32'h01);
        check("reset wr_ack", {31'h0, bus.wr_ack}, 32'h0);
        for (int i = 0; i < 8; i++) begin
            bus.rd_sel_a = 3'(i);
            bus.rd_sel_b = 3'(7 - i);
            #1;
            check($sformatf("reset rd_a[%0d]", i), bus.rd_data_a, 32'h0);
            check($sformatf("reset rd_b[%0d]", 7 - i), bus.rd_data_b, 32'h0);
            check($sformatf("reset vld_a[%0d]", i), {31'h0, bus.rd_vld_a}, (i == 0) ? 32'h1 : 32'h0);
        end

        for (int i = 0; i < 9; i++) begin
            drive(vec[i].wr_en, vec[i].wr_sel, vec[i].wr_data);
            bus.rd_sel_a = vec[i].rd_sel_a;
            bus.rd_sel_b = vec[i].rd_sel_b;
            #1;
            check($sformatf("row%0d rd_a", i), bus.rd_data_a, vec[i].exp_a);
            check($sformatf("row%0d rd_b", i), bus.rd_data_b, vec[i].exp_b);
            check($sformatf("row%0d vld_a", i), {31'h0, bus.rd_vld_a}, {31'h0, vec[i].exp_vld_a});
            check($sformatf("row%0d vld_b", i), {31'h0, bus.rd_vld_b}, {31'h0, vec[i].exp_vld_b});
            check($sformatf("row%0d wr_ack", i), {31'h0, bus.wr_ack}, {31'h0, vec[i].exp_ack});
            check($sformatf("row%0d mask", i), {24'h0, bus.valid_mask}, {24'h0, vec[i].exp_mask});
            check($sformatf("row%0d nb rd_a", i), bus_nb.rd_data_a, vec[i].nb_a);
            check($sformatf("row%0d nb rd_b", i), bus_nb.rd_data_b, vec[i].nb_b);
            check($sformatf("row%0d nb vld_a", i), {31'h0, bus_nb.rd_vld_a},
                  {31'h0, vec[i].nb_vld_a});
            check($sformatf("row%0d nb vld_b", i), {31'h0, bus_nb.rd_vld_b},
                  {31'h0, vec[i].nb_vld_b});
            step();
        end

        // Back-to-back sweep of entries 1..7
        for (int i = 1; i < 8; i++) begin
            drive(1'b1, 3'(i), 32'h100 + 32'(i));
            #1;
            check($sformatf("sweep ack@%0d", i), {31'h0, bus.wr_ack}, (i == 1) ? 32'h0 : 32'h1);
            step();
        end
        drive(1'b0, 3'd0, 32'h0);
        #1;
        check("sweep ack tail", {31'h0, bus.wr_ack}, 32'h1);
        check("sweep mask", {24'h0, bus.valid_mask}, 32'hFF);
        step();
        check("sweep ack drop", {31'h0, bus.wr_ack}, 32'h0);
        for (int i = 0; i < 8; i++) begin
            bus.rd_sel_a = 3'(i);
            bus.rd_sel_b = 3'(i);
            #1;
            check($sformatf("sweep rd_a[%0d]", i), bus.rd_data_a, (i == 0) ? 32'h0 : 32'h100 + 32'(i));
            check($sformatf("sweep rd_b[%0d]", i), bus.rd_data_b, (i == 0) ? 32'h0 : 32'h100 + 32'(i));
        end

        // Reset lands on a pending write to entry 4
        for (int i = 1; i < 4; i++) begin
            drive(1'b1, 3'(i), 32'h200 + 32'(i));
            step();
        end
        reset = 1'b1;
        drive(1'b1, 3'd4, 32'h204);
        step();
        reset = 1'b0;
        drive(1'b0, 3'd0, 32'h0);
        #1;
        check("midreset mask", {24'h0, bus.valid_mask}, 32'h01);
        check("midreset wr_ack", {31'h0, bus.wr_ack}, 32'h0);
        for (int i = 0; i < 8; i++) begin
            bus.rd_sel_a = 3'(i);
            #1;
            check($sformatf("midreset rd_a[%0d]", i), bus.rd_data_a, 32'h0);
        end
        step();
        check("midreset ack after", {31'h0, bus.wr_ack}, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
